ntt_twiddle_mult: RTL

NTT_TWIDDLE_MULT -- requirements
Module: ntt_twiddle_mult

---
 rtl/ntt_pkg.sv | 38 +++
 rtl/ntt_barrett_reduce.sv | 47 ++++
 rtl/ntt_twiddle_mult.sv | 120 ++++++++++++
 3 files changed

// File: rtl/ntt_pkg.sv
// ----------------------------------------------------------------------------
// ntt_pkg
// Shared definitions for the NTT datapath blocks:
//   NTT_MODULUS / NTT_WIDTH : default prime modulus and data-port width
//   NTT_OP_W / NTT_VAL_W    : reduced-operand width and full-product width
//   ntt_k() / ntt_mu()      : Barrett shift and multiplier for a modulus
//   stage_t                 : pipeline stage payload (valid, buffer word, value)
// ----------------------------------------------------------------------------
package ntt_pkg;

    localparam int unsigned NTT_MODULUS = 7681;
    localparam int unsigned NTT_WIDTH   = 32;

    // Operands are truncated to 16 bits; their product needs 32.
    localparam int unsigned NTT_OP_W  = 16;
    localparam int unsigned NTT_VAL_W = 2 * NTT_OP_W;

    // Buffer field is sized for the widest supported data port so the struct
    // does not depend on the instantiating module's WIDTH.
    localparam int unsigned NTT_BUF_W = 64;

    // Barrett shift: twice the bit length of the modulus.
    function automatic int unsigned ntt_k(input int unsigned q);
        return 2 * $clog2(q);
    endfunction

    // Barrett multiplier: floor(2^K / q). K <= 32 for q < 2^16, so 64 bits suffice.
    function automatic logic [63:0] ntt_mu(input int unsigned q);
        return (64'd1 << ntt_k(q)) / 64'(q);
    endfunction

    typedef struct packed {
        logic                 valid;
        logic [NTT_BUF_W-1:0] buffer;
        logic [NTT_VAL_W-1:0] value;
    } stage_t;

endpackage

// File: rtl/ntt_barrett_reduce.sv
// ----------------------------------------------------------------------------
// ntt_barrett_reduce
// Combinational Barrett datapath, split at the pipeline boundary so the
// caller owns all registers and flow control.
//   i_p    : full product entering the estimate stage
//   o_t    : quotient estimate t = (i_p * MU) >> K
//   i_p_s3 : registered product entering the correction stage
//   i_t_s3 : registered quotient estimate matching i_p_s3
//   o_r    : i_p_s3 mod MODULUS, always < MODULUS
// ----------------------------------------------------------------------------
module ntt_barrett_reduce
    import ntt_pkg::*;
#(
    parameter int unsigned MODULUS = NTT_MODULUS
) (
    input  logic [NTT_VAL_W-1:0] i_p,
    output logic [NTT_VAL_W-1:0] o_t,
    input  logic [NTT_VAL_W-1:0] i_p_s3,
    input  logic [NTT_VAL_W-1:0] i_t_s3,
    output logic [NTT_OP_W-1:0]  o_r
);

    localparam int unsigned K   = ntt_k(MODULUS);
    localparam logic [63:0] MU  = ntt_mu(MODULUS);
    localparam logic [63:0] Q64 = 64'(MODULUS);

    logic [63:0] w_pmu;
    logic [63:0] w_tq;
    logic [63:0] w_r0;
    logic [63:0] w_r1;

    // Estimate stage. MU <= 2^K / q guarantees t <= p / q, so p - t*q never
    // goes negative.
    assign w_pmu = 64'(i_p) * MU;
    assign o_t   = NTT_VAL_W'(w_pmu >> K);

    // Correction stage. For p < 2^K the estimate is short by at most one
    // multiple of q, so a single conditional subtract lands in [0, q).
    assign w_tq = 64'(i_t_s3) * Q64;
    assign w_r0 = 64'(i_p_s3) - w_tq;
    assign w_r1 = (w_r0 >= Q64) ? (w_r0 - Q64) : w_r0;

    // Out-of-range operands can push p past 2^K and leave w_r1 >= q; the
    // result is unspecified then, but must still be a valid residue.
    assign o_r = (w_r1 >= Q64) ? '0 : NTT_OP_W'(w_r1);

endmodule

// File: rtl/ntt_twiddle_mult.sv
// ----------------------------------------------------------------------------
// ntt_twiddle_mult
// Three-stage valid/ready pipeline computing (normal * twiddle) mod MODULUS
// for an NTT butterfly, with the top operand delayed alongside.
//   clk, rst_n       : clock, asynchronous active-low reset
//   in_valid/ready   : upstream handshake
//   buffer_data_in   : butterfly top operand, passed through unchanged
//   normal_data_in   : butterfly bottom operand (low 16 bits used)
//   twiddle_in       : twiddle factor (low 16 bits used)
//   out_valid/ready  : downstream handshake
//   buffer_data_out  : delayed buffer_data_in, aligned with product_out
//   product_out      : modular product, zero-extended to WIDTH
//   range_err        : sticky flag, operand >= MODULUS accepted
// Build option: NTT_TWIDDLE_MULT_RANGE_CHECK_EN enables the range_err check;
// when undefined range_err is tied low.
// ----------------------------------------------------------------------------
module ntt_twiddle_mult
    import ntt_pkg::*;
#(
    parameter int unsigned MODULUS = NTT_MODULUS,
    parameter int unsigned WIDTH   = NTT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] buffer_data_in,
    input  logic [WIDTH-1:0] normal_data_in,
    input  logic [WIDTH-1:0] twiddle_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] buffer_data_out,
    output logic [WIDTH-1:0] product_out,
    output logic             range_err
);

    stage_t               r_s1;
    stage_t               r_s2;
    stage_t               r_s3;
    logic [NTT_VAL_W-1:0] r_s2_t;

    logic                 w_adv;
    logic                 w_accept;
    logic [NTT_BUF_W-1:0] w_buf_ext;
    logic [NTT_VAL_W-1:0] w_p;
    logic [NTT_VAL_W-1:0] w_t;
    logic [NTT_OP_W-1:0]  w_r;
    logic                 w_unused;

    // Whole pipeline moves as one: it can only stall when the output is held.
    assign w_adv    = !r_s3.valid || out_ready;
    assign in_ready = w_adv;
    assign w_accept = in_valid && w_adv;

    // NOTE: default first so every path assigns the full vector; otherwise a latch is inferred.
    always_comb begin
        w_buf_ext              = '0;
        w_buf_ext[WIDTH-1:0]   = buffer_data_in;
    end

    // S1 multiply on the low 16 bits of each operand.
    assign w_p = NTT_VAL_W'(normal_data_in[NTT_OP_W-1:0]) * NTT_VAL_W'(twiddle_in[NTT_OP_W-1:0]);

    ntt_barrett_reduce #(
        .MODULUS (MODULUS)
    ) u_reduce (
        .i_p    (r_s1.value),
        .o_t    (w_t),
        .i_p_s3 (r_s2.value),
        .i_t_s3 (r_s2_t),
        .o_r    (w_r)
    );

    // NOTE: non-blocking assignments so every stage samples its predecessor's pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: data registers are reset too, so the outputs read 0 rather than X after reset.
            r_s1   <= '0;
            r_s2   <= '0;
            r_s3   <= '0;
            r_s2_t <= '0;
        end else if (w_adv) begin
            r_s1.valid  <= in_valid;
            r_s1.buffer <= w_buf_ext;
            r_s1.value  <= w_p;

            r_s2   <= r_s1;
            r_s2_t <= w_t;

            r_s3.valid  <= r_s2.valid;
            r_s3.buffer <= r_s2.buffer;
            r_s3.value  <= NTT_VAL_W'(w_r);
        end
    end

    assign out_valid       = r_s3.valid;
    assign buffer_data_out = r_s3.buffer[WIDTH-1:0];
    assign product_out     = WIDTH'(r_s3.value);

`ifdef NTT_TWIDDLE_MULT_RANGE_CHECK_EN
    logic r_range_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_range_err <= 1'b0;
        end else if (w_accept &&
                     ((normal_data_in >= WIDTH'(MODULUS)) || (twiddle_in >= WIDTH'(MODULUS)))) begin
            r_range_err <= 1'b1;
        end
    end

    assign range_err = r_range_err;
`else
    assign range_err = 1'b0;
`endif

    // Bits that are deliberately ignored (upper operand bits, spare buffer bits).
    assign w_unused = ^{w_accept, normal_data_in, twiddle_in, r_s3.buffer, r_s3.value};

endmodule
